// File: rtl/irrigation_controller.sv
// Irrigation control stage: synchronizes tank/soil probes, runs the watering FSM,
// and drives sprinkler/drip/error outputs plus the tank inlet valve with hysteresis.
`timescale 1ns/1ps
module irrigation_controller #(
  parameter int unsigned MIN_ON_S    = 5,
  parameter int unsigned ERR_CLEAR_S = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second_tick,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       soil_dry,
  input  logic       soil_wet,
  output logic       Bs,
  output logic       Vs,
  output logic       Error,
  output logic       Ve,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SPRINKLE = 2'b01,
    ST_DRIP     = 2'b10,
    ST_ERROR    = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] MinOn    = CNT_W'(MIN_ON_S);
  localparam logic [CNT_W-1:0] ErrClear = CNT_W'(ERR_CLEAR_S);

  logic [4:0]       meta_q;
  logic [4:0]       sync_q;
  logic [4:0]       probes;
  logic             sH, sM, sL, sDry, sWet;
  logic             fault, demand, runDone, keepCnt;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ve_q, ve_d;
  logic             bs_q, vs_q, err_q;

  assign probes = {H, M, L, soil_dry, soil_wet};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= probes;
      sync_q <= meta_q;
    end
  end

  assign {sH, sM, sL, sDry, sWet} = sync_q;

  // Inconsistent level probes (a higher probe wet above a dry lower one) or both soil probes set
  assign fault   = (sH & ~sM) | (sM & ~sL) | (sDry & sWet);
  assign demand  = sDry & ~sWet;
  assign runDone = (cnt_q >= MinOn);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fault)                   state_d = ST_ERROR;
        else if (demand && sL && sM) state_d = ST_SPRINKLE;
        else if (demand && sL)       state_d = ST_DRIP;
      end
      ST_SPRINKLE: begin
        if (fault)                    state_d = ST_ERROR;
        else if (!sL)                 state_d = ST_IDLE;
        else if (!demand && runDone)  state_d = ST_IDLE;
        else if (!sM)                 state_d = ST_DRIP;
      end
      ST_DRIP: begin
        if (fault)                    state_d = ST_ERROR;
        else if (!sL)                 state_d = ST_IDLE;
        else if (!demand && runDone)  state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!fault && cnt_q == ErrClear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A sprinkle run degraded to drip keeps its elapsed time toward the minimum run
  assign keepCnt = (state_q == ST_SPRINKLE) && (state_d == ST_DRIP);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && !keepCnt) begin
      cnt_d = '0;
    end else if ((state_q == ST_ERROR) && fault) begin
      cnt_d = '0;
    end else if (one_second_tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    ve_d = ve_q;
    if (!sL)     ve_d = 1'b1;
    else if (sH) ve_d = 1'b0;
    if (state_d == ST_ERROR) ve_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ve_q    <= 1'b0;
      bs_q    <= 1'b0;
      vs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ve_q    <= ve_d;
      bs_q    <= (state_d == ST_SPRINKLE);
      vs_q    <= (state_d == ST_DRIP);
      err_q   <= (state_d == ST_ERROR);
    end
  end

  assign Bs    = bs_q;
  assign Vs    = vs_q;
  assign Error = err_q;
  assign Ve    = ve_q;
  assign state = state_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed scoreboard bench for irrigation_controller: expectations are queued as
// stimulus is applied and popped when the outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_irrigation_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       one_second_tick;
  logic       H, M, L, soil_dry, soil_wet;
  logic       Bs, Vs, Error, Ve;
  logic [1:0] state;

  typedef struct {
    string      tag;
    logic [5:0] vec;
    logic [5:0] mask;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  irrigation_controller #(
    .MIN_ON_S   (5),
    .ERR_CLEAR_S(3),
    .CNT_W      (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .one_second_tick(one_second_tick),
    .H              (H),
    .M              (M),
    .L              (L),
    .soil_dry       (soil_dry),
    .soil_wet       (soil_wet),
    .Bs             (Bs),
    .Vs             (Vs),
    .Error          (Error),
    .Ve             (Ve),
    .state          (state)
  );

  always #10 clock = ~clock;

  task automatic applyStimulus(input logic h, input logic m, input logic l,
                               input logic dry, input logic wet);
    H = h; M = m; L = l; soil_dry = dry; soil_wet = wet;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseTick();
    one_second_tick = 1'b1;
    @(negedge clock);
    one_second_tick = 1'b0;
  endtask

  // Vector layout: {state[1:0], Bs, Vs, Error, Ve}
  task automatic expectOut(input string tag, input logic [1:0] st, input logic bs,
                           input logic vs, input logic err, input logic ve,
                           input logic [5:0] mask = 6'b111111);
    exp_t e;
    e.tag  = tag;
    e.vec  = {st, bs, vs, err, ve};
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs;
    obs = {state, Bs, Vs, Error, Ve};
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard-empty: observed %b, required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert ((obs & e.mask) === (e.vec & e.mask)) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed state/Bs/Vs/Error/Ve=%b expected %b (mask %b)",
             e.tag, obs, e.vec, e.mask);
    end
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    one_second_tick = 1'b0;
    applyStimulus(1, 1, 1, 1, 0);
    waitCycles(2);
    expectOut("reset", 2'b00, 0, 0, 0, 0);
    checkOutput();

    // Start-up: probes become visible on the third edge after release
    reset_n = 1'b1;
    waitCycles(2);
    expectOut("sync-latency", 2'b00, 0, 0, 0, 0, 6'b111110);
    checkOutput();
    waitCycles(1);
    expectOut("sprinkle-entry", 2'b01, 1, 0, 0, 0);
    checkOutput();

    // Sprinkle degrades to drip after two seconds, run time carries over
    pulseTick();
    pulseTick();
    applyStimulus(0, 1, 1, 1, 0);
    waitCycles(1);
    applyStimulus(0, 0, 1, 1, 0);
    waitCycles(2);
    expectOut("drop-M-latency", 2'b01, 1, 0, 0, 0);
    checkOutput();
    waitCycles(1);
    expectOut("sprinkle-to-drip", 2'b10, 0, 1, 0, 0);
    checkOutput();
    applyStimulus(0, 0, 1, 0, 0);
    waitCycles(3);
    expectOut("drip-min-on-hold", 2'b10, 0, 1, 0, 0);
    checkOutput();
    pulseTick();
    pulseTick();
    pulseTick();
    expectOut("drip-at-min-on", 2'b10, 0, 1, 0, 0);
    checkOutput();
    waitCycles(1);
    expectOut("drip-min-on-exit", 2'b00, 0, 0, 0, 0);
    checkOutput();

    // Empty tank aborts a drip run early and opens the inlet valve
    applyStimulus(0, 0, 1, 1, 0);
    waitCycles(3);
    expectOut("idle-to-drip", 2'b10, 0, 1, 0, 0);
    checkOutput();
    pulseTick();
    applyStimulus(0, 0, 0, 1, 0);
    waitCycles(2);
    expectOut("empty-latency", 2'b10, 0, 1, 0, 0);
    checkOutput();
    waitCycles(1);
    expectOut("empty-abort", 2'b00, 0, 0, 0, 1);
    checkOutput();

    // Level fault, partial recovery, re-fault, then full recovery
    applyStimulus(1, 0, 1, 1, 0);
    waitCycles(3);
    expectOut("level-fault", 2'b11, 0, 0, 1, 0);
    checkOutput();
    applyStimulus(1, 1, 1, 1, 0);
    waitCycles(3);
    pulseTick();
    pulseTick();
    expectOut("error-partial", 2'b11, 0, 0, 1, 0);
    checkOutput();
    applyStimulus(1, 0, 1, 1, 0);
    waitCycles(3);
    applyStimulus(1, 1, 1, 0, 0);
    waitCycles(3);
    pulseTick();
    pulseTick();
    expectOut("error-restart", 2'b11, 0, 0, 1, 0);
    checkOutput();
    pulseTick();
    expectOut("error-at-clear", 2'b11, 0, 0, 1, 0);
    checkOutput();
    waitCycles(1);
    expectOut("error-clear", 2'b00, 0, 0, 0, 0);
    checkOutput();

    // Soil probe conflict fault
    applyStimulus(1, 1, 1, 1, 1);
    waitCycles(3);
    expectOut("soil-fault", 2'b11, 0, 0, 1, 0);
    checkOutput();
    applyStimulus(1, 1, 1, 0, 0);
    waitCycles(3);
    pulseTick();
    pulseTick();
    pulseTick();
    waitCycles(1);
    expectOut("soil-fault-clear", 2'b00, 0, 0, 0, 0);
    checkOutput();

    // Inlet valve hysteresis
    applyStimulus(0, 0, 0, 0, 0);
    waitCycles(3);
    expectOut("ve-set", 2'b00, 0, 0, 0, 1);
    checkOutput();
    applyStimulus(0, 1, 1, 0, 0);
    waitCycles(3);
    expectOut("ve-hold", 2'b00, 0, 0, 0, 1);
    checkOutput();
    applyStimulus(1, 1, 1, 0, 0);
    waitCycles(3);
    expectOut("ve-clear", 2'b00, 0, 0, 0, 0);
    checkOutput();

    // Asynchronous reset mid-run, then a fresh run with a restarted counter
    applyStimulus(1, 1, 1, 1, 0);
    waitCycles(3);
    expectOut("resprinkle", 2'b01, 1, 0, 0, 0);
    checkOutput();
    pulseTick();
    pulseTick();
    #3;
    reset_n = 1'b0;
    #1;
    expectOut("async-reset", 2'b00, 0, 0, 0, 0);
    checkOutput();
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(3);
    expectOut("post-reset-sprinkle", 2'b01, 1, 0, 0, 0);
    checkOutput();
    applyStimulus(1, 1, 1, 0, 0);
    waitCycles(3);
    pulseTick();
    pulseTick();
    pulseTick();
    pulseTick();
    expectOut("fresh-cnt-hold", 2'b01, 1, 0, 0, 0);
    checkOutput();
    pulseTick();
    waitCycles(1);
    expectOut("fresh-cnt-exit", 2'b00, 0, 0, 0, 0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
